// File: rtl/vga_fb_arbiter.sv
// Framebuffer RAM arbiter: display reads win every cycle, buffered writes drain on idle cycles.
// Optional macro VGA_FB_ARB_VBLANK_DRAIN_EN restricts draining (and starvation counting) to vblank.
module vga_fb_arbiter #(
    parameter int AW          = 17,
    parameter int DW          = 12,
    parameter int WFIFO_DEPTH = 8,
    parameter int STARVE_MAX  = 1024
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           disp_req,
    input  logic [AW-1:0]                  disp_addr,
    output logic                           disp_valid,
    output logic [DW-1:0]                  disp_data,
    input  logic                           vblank,
    input  logic                           wr_valid,
    output logic                           wr_ready,
    input  logic [AW-1:0]                  wr_addr,
    input  logic [DW-1:0]                  wr_data,
    output logic [$clog2(WFIFO_DEPTH):0]   wr_pending,
    output logic                           wr_starve,
    output logic [AW-1:0]                  mem_addr,
    output logic                           mem_we,
    output logic [DW-1:0]                  mem_wdata,
    input  logic [DW-1:0]                  mem_rdata
);

    localparam int PW = $clog2(WFIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);

    localparam logic [1:0] GNT_IDLE = 2'd0;
    localparam logic [1:0] GNT_DISP = 2'd1;
    localparam logic [1:0] GNT_WR   = 2'd2;

    logic [AW-1:0] fifo_addr_q [WFIFO_DEPTH];
    logic [DW-1:0] fifo_data_q [WFIFO_DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic          mem_we_q, mem_we_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;

    logic          rd_s1_q, rd_s1_d;
    logic          rd_s2_q, rd_s2_d;
    logic          disp_valid_q, disp_valid_d;
    logic [DW-1:0] disp_data_q, disp_data_d;

    logic [SW-1:0] starve_cnt_q, starve_cnt_d;
    logic          wr_starve_q, wr_starve_d;

    logic [1:0]    gnt;
    logic          fifo_empty;
    logic          fifo_ready;
    logic          push;
    logic          pop;
    logic          drain_ok;

`ifdef VGA_FB_ARB_VBLANK_DRAIN_EN
    assign drain_ok = vblank;
`else
    logic unused_vblank;
    assign unused_vblank = vblank;
    assign drain_ok      = 1'b1;
`endif

    assign fifo_empty = (count_q == '0);
    assign fifo_ready = (count_q != CW'(WFIFO_DEPTH));
    assign push       = wr_valid && fifo_ready;

    always_comb begin
        gnt = GNT_IDLE;
        if (disp_req) begin
            gnt = GNT_DISP;
        end else if (!fifo_empty && drain_ok) begin
            gnt = GNT_WR;
        end
    end

    assign pop = (gnt == GNT_WR);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // RAM command register: address holds on idle cycles so the bus stays quiet.
    always_comb begin
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        case (gnt)
            GNT_DISP: begin
                mem_addr_d = disp_addr;
            end
            GNT_WR: begin
                mem_addr_d  = fifo_addr_q[rd_ptr_q];
                mem_wdata_d = fifo_data_q[rd_ptr_q];
                mem_we_d    = 1'b1;
            end
            default: begin
                mem_we_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        rd_s1_d      = (gnt == GNT_DISP);
        rd_s2_d      = rd_s1_q;
        disp_valid_d = rd_s2_q;
        disp_data_d  = rd_s2_q ? mem_rdata : disp_data_q;
    end

    // Starvation only counts cycles where a drain could legally have happened.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (pop || fifo_empty) begin
            starve_cnt_d = '0;
        end else if (!drain_ok) begin
            starve_cnt_d = starve_cnt_q;
        end else if (starve_cnt_q != SW'(STARVE_MAX)) begin
            starve_cnt_d = starve_cnt_q + SW'(1);
        end
        wr_starve_d = (starve_cnt_d == SW'(STARVE_MAX));
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= wr_addr;
            fifo_data_q[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            mem_addr_q   <= '0;
            mem_we_q     <= 1'b0;
            mem_wdata_q  <= '0;
            rd_s1_q      <= 1'b0;
            rd_s2_q      <= 1'b0;
            disp_valid_q <= 1'b0;
            disp_data_q  <= '0;
            starve_cnt_q <= '0;
            wr_starve_q  <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            mem_addr_q   <= mem_addr_d;
            mem_we_q     <= mem_we_d;
            mem_wdata_q  <= mem_wdata_d;
            rd_s1_q      <= rd_s1_d;
            rd_s2_q      <= rd_s2_d;
            disp_valid_q <= disp_valid_d;
            disp_data_q  <= disp_data_d;
            starve_cnt_q <= starve_cnt_d;
            wr_starve_q  <= wr_starve_d;
        end
    end

    assign wr_ready   = fifo_ready;
    assign wr_pending = count_q;
    assign wr_starve  = wr_starve_q;
    assign mem_addr   = mem_addr_q;
    assign mem_we     = mem_we_q;
    assign mem_wdata  = mem_wdata_q;
    assign disp_valid = disp_valid_q;
    assign disp_data  = disp_data_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed self-checking bench for vga_fb_arbiter with a behavioural 1-cycle-latency RAM.
// Covers the vblank-gated drain path only when VGA_FB_ARB_VBLANK_DRAIN_EN is defined.
module tb_vga_fb_arbiter;

    localparam int AW         = 17;
    localparam int DW         = 12;
    localparam int STARVE_MAX = 1024;

`ifdef VGA_FB_ARB_VBLANK_DRAIN_EN
    localparam logic VB = 1'b1;
`else
    localparam logic VB = 1'b0;
`endif

    logic          clk;
    logic          rstn;
    logic          disp_req;
    logic [AW-1:0] disp_addr;
    logic          disp_valid;
    logic [DW-1:0] disp_data;
    logic          vblank;
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [3:0]    wr_pending;
    logic          wr_starve;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic          pre_en;
    logic [AW-1:0] pre_addr;
    logic [DW-1:0] pre_data;
    logic [DW-1:0] ram [0:(1<<AW)-1];

    int tests;
    int fails;

    vga_fb_arbiter #(
        .AW(AW), .DW(DW), .WFIFO_DEPTH(8), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk), .rstn(rstn),
        .disp_req(disp_req), .disp_addr(disp_addr),
        .disp_valid(disp_valid), .disp_data(disp_data),
        .vblank(vblank),
        .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_pending(wr_pending), .wr_starve(wr_starve),
        .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port RAM, read-first, data one cycle after the address.
    always @(posedge clk) begin
        if (pre_en) begin
            ram[pre_addr] <= pre_data;
        end else if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
        end
        mem_rdata <= ram[mem_addr];
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        rstn      = 1'b0;
        disp_req  = 1'b0;
        disp_addr = '0;
        vblank    = VB;
        wr_valid  = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        mem_rdata = '0;
        pre_en    = 1'b1;
        pre_addr  = 17'h00010;
        pre_data  = 12'hF0F;

        step(1);
        pre_en = 1'b0;
        step(1);
        check("rst_wr_ready",   32'(wr_ready),   32'd1);
        check("rst_wr_pending", 32'(wr_pending), 32'd0);
        check("rst_mem_we",     32'(mem_we),     32'd0);
        check("rst_disp_valid", 32'(disp_valid), 32'd0);
        check("rst_wr_starve",  32'(wr_starve),  32'd0);
        check("rst_mem_addr",   32'(mem_addr),   32'd0);
        check("rst_disp_data",  32'(disp_data),  32'd0);
        rstn = 1'b1;
        step(1);

        // Display read, latency 3
        disp_req  = 1'b1;
        disp_addr = 17'h00010;
        step(1);
        check("rd_mem_addr",  32'(mem_addr),   32'h10);
        check("rd_mem_we",    32'(mem_we),     32'd0);
        check("rd_valid_n1",  32'(disp_valid), 32'd0);
        disp_req = 1'b0;
        step(1);
        check("rd_valid_n2",  32'(disp_valid), 32'd0);
        step(1);
        check("rd_valid_n3",  32'(disp_valid), 32'd1);
        check("rd_data_n3",   32'(disp_data),  32'hF0F);
        step(1);
        check("rd_valid_n4",  32'(disp_valid), 32'd0);

        // Single write drains two cycles after the push
        wr_valid = 1'b1;
        wr_addr  = 17'h00005;
        wr_data  = 12'hABC;
        step(1);
        check("wr1_pending_p1", 32'(wr_pending), 32'd1);
        check("wr1_we_p1",      32'(mem_we),     32'd0);
        wr_valid = 1'b0;
        step(1);
        check("wr1_we_p2",      32'(mem_we),     32'd1);
        check("wr1_addr_p2",    32'(mem_addr),   32'h5);
        check("wr1_wdata_p2",   32'(mem_wdata),  32'hABC);
        check("wr1_pending_p2", 32'(wr_pending), 32'd0);
        step(1);
        check("idle_we",        32'(mem_we),     32'd0);
        check("idle_addr_hold", 32'(mem_addr),   32'h5);

        // Read back the written word
        disp_req  = 1'b1;
        disp_addr = 17'h00005;
        step(1);
        disp_req = 1'b0;
        step(2);
        check("rb_valid", 32'(disp_valid), 32'd1);
        check("rb_data",  32'(disp_data),  32'hABC);

        // Fill the FIFO while the display owns the RAM
        disp_req  = 1'b1;
        disp_addr = 17'h00000;
        for (int i = 0; i < 8; i++) begin
            wr_valid = 1'b1;
            wr_addr  = 17'h00100 + 17'(i);
            wr_data  = 12'h300 + 12'(i);
            step(1);
            check("fill_we", 32'(mem_we), 32'd0);
        end
        check("full_pending", 32'(wr_pending), 32'd8);
        check("full_ready",   32'(wr_ready),   32'd0);
        wr_addr = 17'h001FF;
        wr_data = 12'hFFF;
        step(1);
        check("full_drop_pending", 32'(wr_pending), 32'd8);
        check("full_drop_we",      32'(mem_we),     32'd0);
        wr_valid = 1'b0;
        disp_req = 1'b0;
        step(1);
        for (int k = 0; k < 8; k++) begin
            check("drain_we",      32'(mem_we),     32'd1);
            check("drain_addr",    32'(mem_addr),   32'h100 + 32'(k));
            check("drain_wdata",   32'(mem_wdata),  32'h300 + 32'(k));
            check("drain_pending", 32'(wr_pending), 32'(7 - k));
            step(1);
        end
        check("drain_done_we",      32'(mem_we),     32'd0);
        check("drain_done_pending", 32'(wr_pending), 32'd0);

        // Starvation under continuous display traffic
        disp_req = 1'b1;
        wr_valid = 1'b1;
        wr_addr  = 17'h00042;
        wr_data  = 12'h123;
        step(1);
        wr_valid = 1'b0;
        step(STARVE_MAX - 1);
        check("starve_before", 32'(wr_starve),  32'd0);
        check("starve_pend",   32'(wr_pending), 32'd1);
        check("starve_we",     32'(mem_we),     32'd0);
        step(1);
        check("starve_hit",    32'(wr_starve),  32'd1);
        step(2);
        check("starve_sat",    32'(wr_starve),  32'd1);
        disp_req = 1'b0;
        step(1);
        check("starve_pop_we",   32'(mem_we),    32'd1);
        check("starve_pop_addr", 32'(mem_addr),  32'h42);
        check("starve_clear",    32'(wr_starve), 32'd0);

        // Reset aborts an in-flight read
        step(1);
        disp_req  = 1'b1;
        disp_addr = 17'h00010;
        step(1);
        rstn     = 1'b0;
        disp_req = 1'b0;
        step(1);
        check("abort_valid_rst", 32'(disp_valid), 32'd0);
        check("abort_addr_rst",  32'(mem_addr),   32'd0);
        rstn = 1'b1;
        step(1);
        check("abort_valid_n3",  32'(disp_valid), 32'd0);
        step(1);
        check("abort_valid_n4",  32'(disp_valid), 32'd0);

        // Reset in the middle of a drain discards the rest
        disp_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1'b1;
            wr_addr  = 17'h00200 + 17'(i);
            wr_data  = 12'h400 + 12'(i);
            step(1);
        end
        wr_valid = 1'b0;
        disp_req = 1'b0;
        step(1);
        check("md_we1",   32'(mem_we),   32'd1);
        check("md_addr1", 32'(mem_addr), 32'h200);
        step(1);
        check("md_addr2", 32'(mem_addr), 32'h201);
        rstn = 1'b0;
        step(1);
        check("md_rst_we",      32'(mem_we),     32'd0);
        check("md_rst_pending", 32'(wr_pending), 32'd0);
        check("md_rst_ready",   32'(wr_ready),   32'd1);
        rstn = 1'b1;
        step(2);
        check("md_after_we",      32'(mem_we),     32'd0);
        check("md_after_pending", 32'(wr_pending), 32'd0);

`ifdef VGA_FB_ARB_VBLANK_DRAIN_EN
        // Drain held off outside blanking
        vblank   = 1'b0;
        disp_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wr_valid = 1'b1;
            wr_addr  = 17'h00300 + 17'(i);
            wr_data  = 12'h500 + 12'(i);
            step(1);
        end
        wr_valid = 1'b0;
        step(2);
        check("vb_hold_we",      32'(mem_we),     32'd0);
        check("vb_hold_pending", 32'(wr_pending), 32'd3);
        vblank = 1'b1;
        step(1);
        check("vb_addr0", 32'(mem_addr), 32'h300);
        check("vb_we0",   32'(mem_we),   32'd1);
        step(1);
        check("vb_addr1", 32'(mem_addr), 32'h301);
        step(1);
        check("vb_addr2",    32'(mem_addr),   32'h302);
        check("vb_pending",  32'(wr_pending), 32'd0);
        step(1);
        check("vb_done_we",  32'(mem_we),     32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
